// File: rtl/serial_operand_demux_if.sv
// Bundles the control, serial data and operand outputs of serial_operand_demux.
// The master drives the frame controls and the slave (the demux) drives the operands.
interface serial_operand_demux_if #(
    parameter int unsigned WIDTH = 16
);
    logic             inStart;
    logic             inSel;
    logic             inBit;
    logic             inValid;
    logic             inClear;
    logic [WIDTH-1:0] outA;
    logic [WIDTH-1:0] outB;
    logic             outValidA;
    logic             outValidB;
    logic             outPair;
    logic             outDone;
    logic             outBusy;

    modport master (
        output inStart, inSel, inBit, inValid, inClear,
        input  outA, outB, outValidA, outValidB, outPair, outDone, outBusy
    );

    modport slave (
        input  inStart, inSel, inBit, inValid, inClear,
        output outA, outB, outValidA, outValidB, outPair, outDone, outBusy
    );
endinterface

// File: rtl/serial_operand_demux.sv
// Deserializes an LSB-first bit stream into a WIDTH-bit word and routes it to operand A or B,
// with per-operand valid flags so the adder can start once both operands are present.
module serial_operand_demux #(
    parameter int unsigned WIDTH = 16
) (
    input logic                  inClk,
    input logic                  inRst,
    serial_operand_demux_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StShift} stateE;

    stateE            stateQ, stateD;
    logic [CntW-1:0]  cntQ, cntD;
    logic [WIDTH-1:0] shregQ, shregD;
    logic             destQ, destD;
    logic [WIDTH-1:0] aQ, aD;
    logic [WIDTH-1:0] bQ, bD;
    logic             validAQ, validAD;
    logic             validBQ, validBD;
    logic             doneQ, doneD;
    logic [WIDTH-1:0] shifted;
    logic             store;

    always_ff @(posedge inClk) begin
        if (inRst) begin
            stateQ  <= StIdle;
            cntQ    <= '0;
            shregQ  <= '0;
            destQ   <= 1'b0;
            aQ      <= '0;
            bQ      <= '0;
            validAQ <= 1'b0;
            validBQ <= 1'b0;
            doneQ   <= 1'b0;
        end else begin
            stateQ  <= stateD;
            cntQ    <= cntD;
            shregQ  <= shregD;
            destQ   <= destD;
            aQ      <= aD;
            bQ      <= bD;
            validAQ <= validAD;
            validBQ <= validBD;
            doneQ   <= doneD;
        end
    end

    always_comb begin
        stateD  = stateQ;
        cntD    = cntQ;
        shregD  = shregQ;
        destD   = destQ;
        aD      = aQ;
        bD      = bQ;
        validAD = validAQ;
        validBD = validBQ;
        store   = 1'b0;
        shifted = {bus.inBit, shregQ[WIDTH-1:1]};

        unique case (stateQ)
            StIdle: begin
                if (bus.inStart) begin
                    destD  = bus.inSel;
                    cntD   = '0;
                    shregD = '0;
                    stateD = StShift;
                end
            end
            StShift: begin
                if (bus.inValid) begin
                    shregD = shifted;
                    cntD   = cntQ + CntW'(1);
                    if (cntQ == LastCnt) begin
                        store  = 1'b1;
                        stateD = StIdle;
                    end
                end
            end
            default: stateD = StIdle;
        endcase

        // Clear first so a store on the same edge still leaves its own flag set.
        if (bus.inClear) begin
            validAD = 1'b0;
            validBD = 1'b0;
        end
        if (store) begin
            if (destQ) begin
                bD      = shifted;
                validBD = 1'b1;
            end else begin
                aD      = shifted;
                validAD = 1'b1;
            end
        end
        doneD = store;
    end

    assign bus.outA      = aQ;
    assign bus.outB      = bQ;
    assign bus.outValidA = validAQ;
    assign bus.outValidB = validBQ;
    assign bus.outPair   = validAQ & validBQ;
    assign bus.outDone   = doneQ;
    assign bus.outBusy   = (stateQ == StShift);
endmodule

// File: doc/serial_operand_demux.md
# serial_operand_demux

Sequential 1-to-2 demultiplexer and deserializer that feeds the 16-bit full adder/subtractor. Receives an operand as an LSB-first serial bit stream, assembles it into a WIDTH-bit word and routes the word into operand register A or B, selected once per frame. It works in the opposite direction to the 2:1 switch-level selector, which merges two sources onto one line. This block splits one line into two destinations. Downstream logic starts an add or subtract when both operands are flagged valid.

## Interface
- WIDTH, 16, operand width in bits; legal range WIDTH ≥ 2
- inClk  in  1  sole clock; all state updates on the rising edge
- inRst  in  1  synchronous, active-high reset
- inStart  in  1  frame start; sampled only in IDLE; the start cycle carries no data bit
- inSel  in  1  destination, sampled together with inStart: 0 → A, 1 → B
- inBit  in  1  serial data, LSB first
- inValid  in  1  qualifies inBit; sampled only in SHIFT
- inClear  in  1  clears both valid flags
- outA  out  WIDTH  operand A register
- outB  out  WIDTH  operand B register
- outValidA  out  1  A holds a completed word
- outValidB  out  1  B holds a completed word
- outPair  out  1  equals outValidA & outValidB (combinational)
- outDone  out  1  one-cycle pulse, one cycle after a word is stored
- outBusy  out  1  high while in SHIFT

## Operation
- The block has one clock, inClk. Reset inRst is synchronous and active-high.
- States are IDLE and SHIFT. The state is internal; outBusy exposes SHIFT.
- IDLE, inStart=1:
  - latch inSel into an internal destination bit
  - clear the bit counter and shift register
  - go to SHIFT
- IDLE, inStart=0: hold. inValid and inBit are ignored in IDLE.
- SHIFT, inValid=1: shift the register right and insert inBit at the MSB (shreg ← {inBit, shreg[WIDTH-1:1]}). Increment the counter.
- SHIFT, inValid=0: hold. Gaps of any length are legal.
- SHIFT, final bit (counter = WIDTH-1 and inValid=1), all on the same edge:
  - write {inBit, shreg[WIDTH-1:1]} to outA or outB, as chosen by the latched destination
  - set the matching valid flag
  - return to IDLE
- inStart during SHIFT is ignored. The frame in progress continues.
- A new frame into an already-valid register overwrites it. Its flag stays 1.
- inClear=1 clears outValidA and outValidB. outA and outB keep their data.
- inClear on the same edge as a store: the stored register's flag ends at 1 and the other flag ends at 0.
- Counter width is clog2(WIDTH+1). No arithmetic is done on the data, so no overflow is possible.

## Timing
- Reset values, effective on the first edge with inRst=1:
  - state IDLE, counter 0, shift register 0, destination 0
  - outA=0, outB=0
  - outValidA, outValidB, outPair, outDone, outBusy all 0
- Reset takes priority over every other input. Reset during SHIFT drops the partial word. Registers hold no data from the aborted frame.
- Frame latency with no gaps:
  - start edge, then WIDTH data edges
  - outA/outB and the valid flag update on data edge WIDTH
  - outDone is high during the cycle after that edge
- outBusy is high from the edge after the start through the final data edge. It is low the cycle after the store, so a new inStart is accepted in that cycle.
- Back-to-back frames: inStart is accepted the cycle after the final bit. Minimum period is WIDTH+1 cycles per operand.
- outPair follows the flags with zero-cycle latency.

## Test plan
- Reset, then check outputs. Start with inSel=0, then 16 consecutive valid bits of 0xA5C3 sent LSB first. Required: outA=0xA5C3 and outValidA=1 after bit 16, outDone one cycle later, outBusy low, outB=0.
- Load B with 0x1234 using random inValid gaps (up to 5 cycles) and inBit toggling while inValid=0. Required: outB=0x1234, outA still 0xA5C3, outPair=1.
- Assert inStart (inSel=1) after 8 bits of a frame with inSel=0 carrying 0xFFFF. Required: the second start is ignored, outA=0xFFFF, outB unchanged.
- Apply inRst after 7 bits of a frame. Required: all outputs 0 on the next cycle. A following full frame of 0x0001 into A gives outA=0x0001.
- inClear on the same edge as the final bit of a B frame of 0x8000, with outValidA=1. Required: outB=0x8000, outValidB=1, outValidA=0, outA data retained.
- Back-to-back frames A=0x00FF and B=0xFF00, second inStart the cycle after the first store. Required: both stored, outPair=1 at cycle 34 from the first start.
